alu_exec_m: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_core_m.sv | 75 +++++++
 rtl/alu_exec_m.sv | 101 ++++++++++
 tb/tb_alu_exec_m.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: widths, operation codes and
// the packed result entry carried through the output register and skid.
package alu_pkg;

    localparam int unsigned DEFAULT_DATA_W = 64;
    localparam int unsigned CODE_W         = 4;
    localparam int unsigned MOV_IMM_W      = 16;
    localparam int unsigned MOV_HW_W       = 2;

    localparam logic [CODE_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [CODE_W-1:0] ALU_SUB  = 4'b1010;
    localparam logic [CODE_W-1:0] ALU_AND  = 4'b0110;
    localparam logic [CODE_W-1:0] ALU_ORR  = 4'b0100;
    localparam logic [CODE_W-1:0] ALU_EOR  = 4'b1001;
    localparam logic [CODE_W-1:0] ALU_CBZ  = 4'b0111;
    localparam logic [CODE_W-1:0] ALU_CBNZ = 4'b1111;
    localparam logic [CODE_W-1:0] ALU_MOVE = 4'b1101;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] result;
        logic                      n;
        logic                      z;
        logic                      c;
        logic                      v;
        logic                      branch_taken;
        logic                      illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_core_m.sv
// Combinational ALU datapath: turns one operation into a complete result entry.
// Ports: alu_control/op_a/op_b/mov_imm/mov_hw in, entry_c (result + flags) out.
module alu_core_m
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic [CODE_W-1:0]    alu_control,
    input  logic [DATA_W-1:0]    op_a,
    input  logic [DATA_W-1:0]    op_b,
    input  logic [MOV_IMM_W-1:0] mov_imm,
    input  logic [MOV_HW_W-1:0]  mov_hw,
    output alu_entry_t           entry_c
);

    logic              is_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum_w;
    logic [DATA_W-1:0] res;
    logic              c;
    logic              v;
    logic              bt;
    logic              il;

    // Shared adder: SUB is a + ~b + 1, so carry-out means "no borrow".
    always_comb begin
        is_sub = (alu_control == ALU_SUB);
        b_eff  = is_sub ? ~op_b : op_b;
        sum_w  = {1'b0, op_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    end

    // Operation select with flag generation.
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        bt  = 1'b0;
        il  = 1'b0;
        case (alu_control)
            ALU_ADD, ALU_SUB: begin
                res = sum_w[DATA_W-1:0];
                c   = sum_w[DATA_W];
                // Overflow: both addends share a sign that the sum does not.
                v   = (op_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                      (sum_w[DATA_W-1] != op_a[DATA_W-1]);
            end
            ALU_AND:  res = op_a & op_b;
            ALU_ORR:  res = op_a | op_b;
            ALU_EOR:  res = op_a ^ op_b;
            ALU_CBZ: begin
                res = op_a;
                bt  = (op_a == '0);
            end
            ALU_CBNZ: begin
                res = op_a;
                bt  = (op_a != '0);
            end
            ALU_MOVE: res = DATA_W'(mov_imm) << {mov_hw, 4'b0000};
            default:  il  = 1'b1;
        endcase
    end

    // Pack the entry; N/Z are derived from the final result for every op.
    always_comb begin
        entry_c              = '0;
        entry_c.result       = DEFAULT_DATA_W'(res);
        entry_c.n            = res[DATA_W-1];
        entry_c.z            = (res == '0);
        entry_c.c            = c;
        entry_c.v            = v;
        entry_c.branch_taken = bt;
        entry_c.illegal      = il;
    end

endmodule

// File: rtl/alu_exec_m.sv
// Registered execute-stage ALU with valid/ready handshake and one-entry skid.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + operation inputs;
// out_valid/out_ready + registered result, NZCV flags, branch_taken, illegal.
module alu_exec_m
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_W-1:0]    alu_control,
    input  logic [DATA_W-1:0]    op_a,
    input  logic [DATA_W-1:0]    op_b,
    input  logic [MOV_IMM_W-1:0] mov_imm,
    input  logic [MOV_HW_W-1:0]  mov_hw,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    result,
    output logic                 flag_n,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_v,
    output logic                 branch_taken,
    output logic                 illegal
);

    alu_entry_t entry_c;
    alu_entry_t out_q,  out_n;
    alu_entry_t skid_q, skid_n;
    logic       out_valid_n;
    logic       skid_valid, skid_valid_n;
    logic       accept_c;
    logic       drain_c;

    alu_core_m #(.DATA_W(DATA_W)) u_core (
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .mov_imm     (mov_imm),
        .mov_hw      (mov_hw),
        .entry_c     (entry_c)
    );

    // Handshake and routing: skid drains first so order is preserved.
    always_comb begin
        out_n        = out_q;
        skid_n       = skid_q;
        out_valid_n  = out_valid;
        skid_valid_n = skid_valid;
        accept_c     = in_valid && in_ready;
        drain_c      = out_valid && out_ready;

        if (drain_c) begin
            out_valid_n = 1'b0;
        end
        if (drain_c && skid_valid) begin
            out_n        = skid_q;
            out_valid_n  = 1'b1;
            skid_valid_n = 1'b0;
        end
        if (accept_c) begin
            if ((!out_valid || out_ready) && !skid_valid) begin
                out_n       = entry_c;
                out_valid_n = 1'b1;
            end else begin
                skid_n       = entry_c;
                skid_valid_n = 1'b1;
            end
        end
    end

    // State registers; in_ready is registered so it never sees out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            out_q      <= out_n;
            skid_q     <= skid_n;
            out_valid  <= out_valid_n;
            skid_valid <= skid_valid_n;
            in_ready   <= !skid_valid_n;
        end
    end

    always_comb begin
        result       = DATA_W'(out_q.result);
        flag_n       = out_q.n;
        flag_z       = out_q.z;
        flag_c       = out_q.c;
        flag_v       = out_q.v;
        branch_taken = out_q.branch_taken;
        illegal      = out_q.illegal;
    end

endmodule

// File: tb/tb_alu_exec_m.sv
// Self-checking bench for alu_exec_m: directed cases plus randomized traffic
// against a scoreboard fed by an arithmetic reference model.
module tb_alu_exec_m;

    localparam int unsigned W = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_control;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [15:0]   mov_imm;
    logic [1:0]    mov_hw;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          flag_n, flag_z, flag_c, flag_v;
    logic          branch_taken;
    logic          illegal;

    int checks = 0;
    int errors = 0;

    // Expected entry vector: {result, n, z, c, v, branch_taken, illegal}.
    logic [W+5:0] sb[$];
    logic         rst_seen;
    logic         last_acc;
    int           n_drained;

    alu_exec_m #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_control  (alu_control),
        .op_a         (op_a),
        .op_b         (op_b),
        .mov_imm      (mov_imm),
        .mov_hw       (mov_hw),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_v       (flag_v),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+5:0] obs_vec();
        return {result, flag_n, flag_z, flag_c, flag_v, branch_taken, illegal};
    endfunction

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic logic [W+5:0] model(input logic [3:0] code, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [15:0] imm,
                                           input logic [1:0] hw);
        logic [W-1:0]      r;
        logic              c, v, bt, il;
        logic signed [W+1:0] true_s;
        logic signed [W+1:0] sa, sb_s, sr;
        r = '0; c = 0; v = 0; bt = 0; il = 0;
        sa   = $signed({{2{a[W-1]}}, a});
        sb_s = $signed({{2{b[W-1]}}, b});
        case (code)
            4'b0010: begin
                r = a + b;
                c = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
                true_s = sa + sb_s;
                sr = $signed({{2{r[W-1]}}, r});
                v = (true_s != sr);
            end
            4'b1010: begin
                r = a - b;
                c = (a >= b);
                true_s = sa - sb_s;
                sr = $signed({{2{r[W-1]}}, r});
                v = (true_s != sr);
            end
            4'b0110: r = a & b;
            4'b0100: r = a | b;
            4'b1001: r = a ^ b;
            4'b0111: begin r = a; bt = (a == 0); end
            4'b1111: begin r = a; bt = (a != 0); end
            4'b1101: r = W'(imm) << (16 * hw);
            default: il = 1;
        endcase
        return {r, r[W-1], (r == 0), c, v, bt, il};
    endfunction

    // One clock: check at negedge, score the handshake, advance past posedge.
    task automatic cycle();
        logic acc, drn;
        @(negedge clk);
        last_acc = 0;
        if (!rst) begin
            chk("in_ready", in_ready, rst_seen ? 1'b0 : (sb.size() < 2));
            chk("out_valid", out_valid, sb.size() > 0);
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn) begin
                n_drained++;
                if (sb.size() > 0) chk("data", obs_vec(), sb.pop_front());
            end
            if (acc) sb.push_back(model(alu_control, op_a, op_b, mov_imm, mov_hw));
            last_acc = acc;
        end
        @(posedge clk);
        rst_seen = rst;
        if (rst) sb.delete();
        #1;
    endtask

    task automatic set_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [15:0] imm, input logic [1:0] hw);
        alu_control = code; op_a = a; op_b = b; mov_imm = imm; mov_hw = hw;
    endtask

    task automatic dir(input string tag, input logic [3:0] code, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [15:0] imm, input logic [1:0] hw,
                       input logic [W+5:0] exp);
        out_ready = 1;
        set_op(code, a, b, imm, hw);
        in_valid = 1;
        cycle();
        in_valid = 0;
        set_op($urandom, {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 2'($urandom));
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk(tag, obs_vec(), exp);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            4: return W'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0] codes [0:7];
        logic [3:0] s_code [0:3];
        logic [W-1:0] s_a [0:3];
        int idx;
        codes = '{4'b0010, 4'b1010, 4'b0110, 4'b0100, 4'b1001, 4'b0111, 4'b1111, 4'b1101};
        s_code = '{4'b0010, 4'b1010, 4'b1001, 4'b0111};
        s_a = '{64'd10, 64'd20, 64'd30, 64'd0};
        n_drained = 0;
        rst_seen = 1;
        rst = 1; in_valid = 0; out_ready = 0;
        set_op(4'b0000, '0, '0, '0, '0);

        // Reset state.
        cycle(); cycle();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_outputs", obs_vec(), '0);
        rst = 0;
        cycle();
        chk("ready_after_rst", in_ready, 1'b1);

        // Directed operations with fixed expected values.
        dir("add_5_7",  4'b0010, 64'd5, 64'd7, 16'h0, 2'd0, {64'd12, 6'b000000});
        dir("sub_3_3",  4'b1010, 64'd3, 64'd3, 16'h0, 2'd0, {64'd0, 6'b011000});
        dir("sub_0_1",  4'b1010, 64'd0, 64'd1, 16'h0, 2'd0, {64'hFFFF_FFFF_FFFF_FFFF, 6'b100000});
        dir("add_ovf",  4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 16'h0, 2'd0,
            {64'h8000_0000_0000_0000, 6'b100100});
        dir("move",     4'b1101, 64'd9, 64'd9, 16'hBEEF, 2'd2, {64'h0000_BEEF_0000_0000, 6'b000000});
        dir("cbz_0",    4'b0111, 64'd0, 64'd5, 16'h0, 2'd0, {64'd0, 6'b010010});
        dir("cbnz_0",   4'b1111, 64'd0, 64'd5, 16'h0, 2'd0, {64'd0, 6'b010000});
        dir("cbnz_neg", 4'b1111, 64'h8000_0000_0000_0001, 64'd0, 16'h0, 2'd0,
            {64'h8000_0000_0000_0001, 6'b100010});
        dir("illegal",  4'b0000, 64'd5, 64'd7, 16'h1234, 2'd1, {64'd0, 6'b010001});
        cycle();

        // Back-pressure: only two operations fit while downstream stalls.
        out_ready = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            set_op(s_code[idx], s_a[idx], 64'd3, 16'h0, 2'd0);
            in_valid = 1;
            cycle();
            if (last_acc) begin
                idx++;
                if (idx == 2) chk("stream_ready_drop", in_ready, 1'b0);
            end
        end
        chk("stream_accepted", idx, 2);
        n_drained = 0;
        out_ready = 1;
        for (int i = 0; i < 20 && (idx < 4 || sb.size() > 0); i++) begin
            if (idx < 4) begin
                set_op(s_code[idx], s_a[idx], 64'd3, 16'h0, 2'd0);
                in_valid = 1;
            end else begin
                in_valid = 0;
            end
            cycle();
            if (last_acc) idx++;
        end
        in_valid = 0;
        chk("stream_delivered", n_drained, 4);

        // Reset with two operations in flight.
        out_ready = 0;
        for (int i = 0; i < 10 && sb.size() < 2; i++) begin
            set_op(codes[$urandom_range(0, 7)], rand_operand(), rand_operand(), 16'($urandom), 2'($urandom));
            in_valid = 1;
            cycle();
        end
        in_valid = 0;
        chk("inflight_two", sb.size(), 2);
        rst = 1;
        cycle();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_outputs", obs_vec(), '0);
        chk("midrst_in_ready", in_ready, 1'b0);
        rst = 0;
        cycle();
        chk("midrst_ready_after", in_ready, 1'b1);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            set_op(($urandom_range(0, 9) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)],
                   rand_operand(), rand_operand(), 16'($urandom), 2'($urandom));
            cycle();
        end

        // Drain what is left, bounded.
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 10 && sb.size() > 0; i++) cycle();
        chk("final_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
